// File: rtl/draw_field_pipe_pkg.sv
// Shared types, field dimensions and palette for the field renderer.
// Game data layout: field[row][col] colour index, 4x4 preview block.
package draw_field_pipe_pkg;

  localparam int FIELD_ROW_CNT = 20;
  localparam int FIELD_COL_CNT = 10;
  localparam int TETRIS_COLORS_CNT = 8;
  localparam int CIDX_W = $clog2(TETRIS_COLORS_CNT);
  localparam int ROW_W = $clog2(FIELD_ROW_CNT);
  localparam int COL_W = $clog2(FIELD_COL_CNT);

  typedef logic [CIDX_W-1:0] cidx_t;

  typedef struct packed {
    cidx_t [FIELD_ROW_CNT-1:0][FIELD_COL_CNT-1:0] field;
    logic next_block_draw_en;
    cidx_t next_block_color;
    logic [3:0][3:0] next_block_data;
  } game_data_t;

  localparam logic [23:0] COLOR_BRICKS_0 = 24'h101010;
  localparam logic [23:0] COLOR_BRICKS_1 = 24'h00ffff;
  localparam logic [23:0] COLOR_BRICKS_2 = 24'h0000ff;
  localparam logic [23:0] COLOR_BRICKS_3 = 24'hff8000;
  localparam logic [23:0] COLOR_BRICKS_4 = 24'hffff00;
  localparam logic [23:0] COLOR_BRICKS_5 = 24'h00ff00;
  localparam logic [23:0] COLOR_BRICKS_6 = 24'h8000ff;
  localparam logic [23:0] COLOR_BRICKS_7 = 24'hff0000;
  localparam logic [23:0] COLOR_BORDERS = 24'h404040;
  localparam logic [23:0] COLOR_FLASH = 24'hffffff;
  localparam logic [23:0] COLOR_GRID = 24'h202020;

  typedef enum logic [1:0] {
    IDLE, ON, OFF, DONE
  } flash_state_t;

  function automatic logic [23:0] brick_color(input cidx_t idx);
    case (idx)
      3'd0: brick_color = COLOR_BRICKS_0;
      3'd1: brick_color = COLOR_BRICKS_1;
      3'd2: brick_color = COLOR_BRICKS_2;
      3'd3: brick_color = COLOR_BRICKS_3;
      3'd4: brick_color = COLOR_BRICKS_4;
      3'd5: brick_color = COLOR_BRICKS_5;
      3'd6: brick_color = COLOR_BRICKS_6;
      default: brick_color = COLOR_BRICKS_7;
    endcase
  endfunction

endpackage

// File: rtl/draw_field_flash_fsm.sv
// Row-clear flash sequencer: start/busy/done handshake,
// frame and phase counters, latched row mask.
module draw_field_flash_fsm
  import draw_field_pipe_pkg::*;
#(
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_PHASES = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     frame_start_i,
  input  logic                     flash_start_i,
  input  logic [FIELD_ROW_CNT-1:0] flash_rows_i,
  output logic [FIELD_ROW_CNT-1:0] rows_o,
  output logic                     flash_on_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam logic [7:0] FRAMES = 8'(FLASH_FRAMES);
  localparam logic [7:0] PHASES = 8'(FLASH_PHASES);

  flash_state_t state_q, state_d;
  logic [7:0] frame_q, frame_d;
  logic [7:0] phase_q, phase_d;
  logic [FIELD_ROW_CNT-1:0] rows_q, rows_d;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    phase_d = phase_q;
    rows_d = rows_q;
    unique case (state_q)
      IDLE: begin
        if (flash_start_i) begin
          state_d = ON;
          rows_d = flash_rows_i;
          frame_d = FRAMES;
          phase_d = '0;
        end
      end
      ON, OFF: begin
        if (rows_q == '0) begin
          state_d = DONE;
        end else if (frame_start_i) begin
          if (frame_q == 8'd1) begin
            frame_d = FRAMES;
            phase_d = phase_q + 8'd1;
            if (phase_d == PHASES) state_d = DONE;
            else state_d = (state_q == ON) ? OFF : ON;
          end else begin
            frame_d = frame_q - 8'd1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      frame_q <= '0;
      phase_q <= '0;
      rows_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      rows_q <= rows_d;
    end
  end

  assign rows_o = rows_q;
  assign flash_on_o = (state_q == ON);
  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

endmodule

// File: rtl/draw_field_pipe.sv
// Pipelined field + preview renderer, 3-cycle latency, per-frame snapshot.
// Optional DRAW_FIELD_GRID_EN: inner border pixels render COLOR_GRID.
module draw_field_pipe
  import draw_field_pipe_pkg::*;
#(
  parameter int PIX_WIDTH = 12,
  parameter int BRICK_X = 30,
  parameter int BRICK_Y = 30,
  parameter int BORDER_X = 2,
  parameter int BORDER_Y = 2,
  parameter int MAIN_START_X = 300,
  parameter int MAIN_START_Y = 200,
  parameter int NBP_START_X = 650,
  parameter int NBP_BRICK_CNT = 6,
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_PHASES = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [PIX_WIDTH-1:0]     pix_x_i,
  input  logic [PIX_WIDTH-1:0]     pix_y_i,
  input  logic                     pix_valid_i,
  input  logic                     frame_start_i,
  input  game_data_t               game_data_i,
  input  logic [FIELD_ROW_CNT-1:0] flash_rows_i,
  input  logic                     flash_start_i,
  output logic                     flash_busy_o,
  output logic                     flash_done_o,
  output logic [23:0]              vga_data_o,
  output logic                     vga_data_en_o,
  output logic                     vga_valid_o
);

  localparam int PW = PIX_WIDTH;
  localparam int NB_W = $clog2(NBP_BRICK_CNT);
  localparam int NB_OFF_I = (NBP_BRICK_CNT - 4) / 2;
  localparam logic [PW-1:0] MSX = PW'(MAIN_START_X);
  localparam logic [PW-1:0] MSY = PW'(MAIN_START_Y);
  localparam logic [PW-1:0] NSX = PW'(NBP_START_X);
  localparam logic [PW-1:0] MEX =
    PW'(MAIN_START_X + FIELD_COL_CNT * BRICK_X + BORDER_X - 1);
  localparam logic [PW-1:0] MEY =
    PW'(MAIN_START_Y + FIELD_ROW_CNT * BRICK_Y + BORDER_Y - 1);
  localparam logic [PW-1:0] NEX =
    PW'(NBP_START_X + NBP_BRICK_CNT * BRICK_X + BORDER_X - 1);
  localparam logic [PW-1:0] NEY =
    PW'(MAIN_START_Y + NBP_BRICK_CNT * BRICK_Y + BORDER_Y - 1);
  localparam logic [PW-1:0] BXL = PW'(BRICK_X - 1);
  localparam logic [PW-1:0] BYL = PW'(BRICK_Y - 1);
  localparam logic [PW-1:0] BDX = PW'(BORDER_X);
  localparam logic [PW-1:0] BDY = PW'(BORDER_Y);
  localparam logic [PW-1:0] COLS = PW'(FIELD_COL_CNT);
  localparam logic [PW-1:0] ROWS = PW'(FIELD_ROW_CNT);
  localparam logic [PW-1:0] NBC = PW'(NBP_BRICK_CNT);
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [NB_W-1:0] NB_OFF = NB_W'(NB_OFF_I);
  localparam logic [NB_W-1:0] NB_LAST = NB_W'(NB_OFF_I + 3);

  typedef struct packed {
    logic [PW-1:0] idx;
    logic [PW-1:0] w;
  } cnt_t;

  typedef struct packed {
    logic m_in;
    logic m_brick;
    logic [ROW_W-1:0] m_row;
    logic [COL_W-1:0] m_col;
    logic p_in;
    logic p_brick;
    logic [NB_W-1:0] p_row;
    logic [NB_W-1:0] p_col;
    logic grid;
  } s1_t;

  typedef struct packed {
    logic inr;
    logic brick;
    cidx_t idx;
    logic flash;
    logic grid;
  } s2_t;

  function automatic cnt_t step(input cnt_t c,
                                input logic [PW-1:0] last);
    cnt_t r;
    r.idx = c.idx;
    r.w = c.w + ONE;
    if (c.w == last) begin
      r.idx = c.idx + ONE;
      r.w = '0;
    end
    return r;
  endfunction

  cnt_t mx_q, mx_d, px_q, px_d, y_q, y_d;
  cnt_t mx_c, px_c, y_c;
  logic [PW-1:0] y_last_q, y_last_d;
  game_data_t snap_q, snap_d;
  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic [23:0] rgb_q, rgb_d;
  logic en_q, en_d, valid_q, valid_d;
  logic flash_on;
  logic [FIELD_ROW_CNT-1:0] flash_rows;
  logic p_inner;
  logic [1:0] pr, pc;

  draw_field_flash_fsm #(
    .FLASH_FRAMES(FLASH_FRAMES),
    .FLASH_PHASES(FLASH_PHASES)
  ) u_flash (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .frame_start_i(frame_start_i),
    .flash_start_i(flash_start_i),
    .flash_rows_i (flash_rows_i),
    .rows_o       (flash_rows),
    .flash_on_o   (flash_on),
    .busy_o       (flash_busy_o),
    .done_o       (flash_done_o)
  );

  // Counters hold the position of the next pixel; y advances per new line.
  always_comb begin
    mx_c = (pix_x_i == MSX) ? '0 : mx_q;
    px_c = (pix_x_i == NSX) ? '0 : px_q;
    if (pix_y_i == MSY) y_c = '0;
    else if (pix_y_i != y_last_q) y_c = step(y_q, BYL);
    else y_c = y_q;
    snap_d = frame_start_i ? game_data_i : snap_q;
    mx_d = mx_q;
    px_d = px_q;
    y_d = y_q;
    y_last_d = y_last_q;
    s1_d = s1_q;
    s1_valid_d = pix_valid_i;
    if (pix_valid_i) begin
      mx_d = step(mx_c, BXL);
      px_d = step(px_c, BXL);
      y_d = y_c;
      y_last_d = pix_y_i;
      s1_d.m_in = pix_x_i >= MSX && pix_x_i <= MEX &&
                  pix_y_i >= MSY && pix_y_i <= MEY;
      s1_d.m_brick = mx_c.w >= BDX && mx_c.idx < COLS &&
                     y_c.w >= BDY && y_c.idx < ROWS;
      s1_d.m_row = y_c.idx[ROW_W-1:0];
      s1_d.m_col = mx_c.idx[COL_W-1:0];
      s1_d.p_in = pix_x_i >= NSX && pix_x_i <= NEX &&
                  pix_y_i >= MSY && pix_y_i <= NEY;
      s1_d.p_brick = px_c.w >= BDX && px_c.idx < NBC &&
                     y_c.w >= BDY && y_c.idx < NBC;
      s1_d.p_row = y_c.idx[NB_W-1:0];
      s1_d.p_col = px_c.idx[NB_W-1:0];
`ifdef DRAW_FIELD_GRID_EN
      s1_d.grid = s1_d.m_in && !s1_d.m_brick &&
                  !((mx_c.idx == '0 && mx_c.w < BDX) ||
                    mx_c.idx == COLS ||
                    (y_c.idx == '0 && y_c.w < BDY) ||
                    y_c.idx == ROWS);
`else
      s1_d.grid = 1'b0;
`endif
    end
  end

  always_comb begin
    p_inner = s1_q.p_row >= NB_OFF && s1_q.p_row <= NB_LAST &&
              s1_q.p_col >= NB_OFF && s1_q.p_col <= NB_LAST;
    pr = 2'(s1_q.p_row - NB_OFF);
    pc = 2'(s1_q.p_col - NB_OFF);
    s2_d = s2_q;
    s2_valid_d = s1_valid_q;
    if (s1_valid_q) begin
      s2_d.inr = s1_q.m_in || s1_q.p_in;
      s2_d.grid = s1_q.grid;
      s2_d.idx = '0;
      s2_d.flash = 1'b0;
      if (s1_q.m_in) begin
        s2_d.brick = s1_q.m_brick;
        if (s1_q.m_brick) begin
          s2_d.idx = snap_q.field[s1_q.m_row][s1_q.m_col];
          s2_d.flash = flash_on && flash_rows[s1_q.m_row];
        end
      end else begin
        s2_d.brick = s1_q.p_brick;
        if (s1_q.p_brick && p_inner && snap_q.next_block_draw_en &&
            snap_q.next_block_data[pr][pc])
          s2_d.idx = snap_q.next_block_color;
      end
    end
  end

  always_comb begin
    rgb_d = rgb_q;
    en_d = en_q;
    valid_d = s2_valid_q;
    if (s2_valid_q) begin
      en_d = s2_q.inr;
      if (!s2_q.inr) rgb_d = COLOR_BORDERS;
      else if (!s2_q.brick)
        rgb_d = s2_q.grid ? COLOR_GRID : COLOR_BORDERS;
      else if (s2_q.flash) rgb_d = COLOR_FLASH;
      else rgb_d = brick_color(s2_q.idx);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mx_q <= '0;
      px_q <= '0;
      y_q <= '0;
      y_last_q <= '0;
      snap_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      rgb_q <= '0;
      en_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      mx_q <= mx_d;
      px_q <= px_d;
      y_q <= y_d;
      y_last_q <= y_last_d;
      snap_q <= snap_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      rgb_q <= rgb_d;
      en_q <= en_d;
      valid_q <= valid_d;
    end
  end

  assign vga_data_o = rgb_q;
  assign vga_data_en_o = en_q;
  assign vga_valid_o = valid_q;

endmodule

// File: tb/tb_draw_field_pipe.sv
// Directed bench for draw_field_pipe with a pixel scoreboard.
// Flash timing shortened to 2 frames x 2 phases.
module tb_draw_field_pipe;
  import draw_field_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_i;
  logic [11:0] pix_x_i, pix_y_i;
  logic pix_valid_i, frame_start_i, flash_start_i;
  game_data_t game_data_i;
  logic [FIELD_ROW_CNT-1:0] flash_rows_i;
  logic flash_busy_o, flash_done_o;
  logic [23:0] vga_data_o;
  logic vga_data_en_o, vga_valid_o;

  typedef struct {
    logic [23:0] rgb;
    logic en;
    int x;
    int y;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  game_data_t live, snap;
  logic flash_on_exp;
  logic [FIELD_ROW_CNT-1:0] mask_exp;

  always #5 clk = ~clk;

  draw_field_pipe #(
    .FLASH_FRAMES(2),
    .FLASH_PHASES(2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .pix_x_i      (pix_x_i),
    .pix_y_i      (pix_y_i),
    .pix_valid_i  (pix_valid_i),
    .frame_start_i(frame_start_i),
    .game_data_i  (game_data_i),
    .flash_rows_i (flash_rows_i),
    .flash_start_i(flash_start_i),
    .flash_busy_o (flash_busy_o),
    .flash_done_o (flash_done_o),
    .vga_data_o   (vga_data_o),
    .vga_data_en_o(vga_data_en_o),
    .vga_valid_o  (vga_valid_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, want);
    end
  endtask

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    int c, r, wx, wy;
    cidx_t idx;
    e.x = x;
    e.y = y;
    e.en = 1'b0;
    e.rgb = COLOR_BORDERS;
    if (x >= 300 && x <= 601 && y >= 200 && y <= 801) begin
      c = (x - 300) / 30; wx = (x - 300) % 30;
      r = (y - 200) / 30; wy = (y - 200) % 30;
      e.en = 1'b1;
      if (wx >= 2 && wy >= 2 && c < 10 && r < 20) begin
        if (flash_on_exp && mask_exp[r]) e.rgb = COLOR_FLASH;
        else e.rgb = brick_color(snap.field[r][c]);
      end else begin
`ifdef DRAW_FIELD_GRID_EN
        if (!(c == 10 || r == 20 || (c == 0 && wx < 2) ||
              (r == 0 && wy < 2)))
          e.rgb = COLOR_GRID;
`endif
      end
    end else if (x >= 650 && x <= 831 && y >= 200 && y <= 381) begin
      c = (x - 650) / 30; wx = (x - 650) % 30;
      r = (y - 200) / 30; wy = (y - 200) % 30;
      e.en = 1'b1;
      if (wx >= 2 && wy >= 2 && c < 6 && r < 6) begin
        idx = '0;
        if (r >= 1 && r <= 4 && c >= 1 && c <= 4 &&
            snap.next_block_draw_en &&
            snap.next_block_data[r-1][c-1])
          idx = snap.next_block_color;
        e.rgb = brick_color(idx);
      end
    end
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    pix_x_i = 12'(x);
    pix_y_i = 12'(y);
    pix_valid_i = 1'b1;
    sb.push_back(model(x, y));
    tick();
    pix_valid_i = 1'b0;
  endtask

  task automatic goto(input int x0, input int x, input int y);
    for (int yy = 200; yy < y; yy++) pix(0, yy);
    for (int xx = x0; xx <= x; xx++) pix(xx, y);
  endtask

  task automatic drain;
    repeat (5) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic frame;
    game_data_i = live;
    frame_start_i = 1'b1;
    snap = live;
    tick();
    frame_start_i = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && vga_valid_o) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk($sformatf("rgb(%0d,%0d)", e.x, e.y),
              32'(vga_data_o), 32'(e.rgb));
          chk($sformatf("en(%0d,%0d)", e.x, e.y),
              32'(vga_data_en_o), 32'(e.en));
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    pix_x_i = '0;
    pix_y_i = '0;
    pix_valid_i = 1'b0;
    frame_start_i = 1'b0;
    flash_start_i = 1'b0;
    flash_rows_i = '0;
    live = '0;
    snap = '0;
    game_data_i = '0;
    flash_on_exp = 1'b0;
    mask_exp = '0;
    repeat (3) tick();
    chk("rst_data", 32'(vga_data_o), 32'd0);
    chk("rst_en", 32'(vga_data_en_o), 32'd0);
    chk("rst_valid", 32'(vga_valid_o), 32'd0);
    chk("rst_busy", 32'(flash_busy_o), 32'd0);
    chk("rst_done", 32'(flash_done_o), 32'd0);
    rst_i = 1'b0;
    tick();

    pix(300, 200);
    chk("lat_valid_early", 32'(vga_valid_o), 32'd0);
    tick();
    chk("lat_valid_early2", 32'(vga_valid_o), 32'd0);
    tick();
    chk("lat_valid_3", 32'(vga_valid_o), 32'd1);
    chk("lat_data_3", 32'(vga_data_o), 32'(COLOR_BORDERS));
    drain();
    pix(0, 0);
    drain();

    live.field[1][1] = 3'd3;
    live.field[2][0] = 3'd7;
    frame();
    goto(290, 335, 235);
    drain();
    live.field[1][1] = 3'd6;
    game_data_i = live;
    goto(290, 335, 235);
    drain();
    frame();
    goto(300, 605, 235);
    drain();

    live.next_block_draw_en = 1'b1;
    live.next_block_color = 3'd5;
    live.next_block_data[0][0] = 1'b1;
    frame();
    goto(640, 690, 235);
    goto(640, 660, 205);
    drain();
    goto(300, 304, 801);
    pix(300, 802);
    drain();

    flash_rows_i = 20'h00002;
    flash_start_i = 1'b1;
    tick();
    flash_start_i = 1'b0;
    chk("fl_busy", 32'(flash_busy_o), 32'd1);
    flash_on_exp = 1'b1;
    mask_exp = 20'h00002;
    goto(300, 335, 235);
    drain();
    flash_rows_i = '0;
    flash_start_i = 1'b1;
    tick();
    flash_start_i = 1'b0;
    chk("fl_ignored_busy", 32'(flash_busy_o), 32'd1);
    frame();
    chk("fl_f1_done", 32'(flash_done_o), 32'd0);
    frame();
    flash_on_exp = 1'b0;
    chk("fl_f2_busy", 32'(flash_busy_o), 32'd1);
    goto(300, 335, 235);
    drain();
    frame();
    chk("fl_f3_done", 32'(flash_done_o), 32'd0);
    frame();
    chk("fl_done", 32'(flash_done_o), 32'd1);
    chk("fl_done_busy", 32'(flash_busy_o), 32'd1);
    tick();
    chk("fl_done_end", 32'(flash_done_o), 32'd0);
    chk("fl_idle", 32'(flash_busy_o), 32'd0);

    flash_rows_i = 20'h00004;
    flash_start_i = 1'b1;
    frame_start_i = 1'b1;
    tick();
    flash_start_i = 1'b0;
    frame_start_i = 1'b0;
    repeat (3) frame();
    chk("same_cyc_done_early", 32'(flash_done_o), 32'd0);
    chk("same_cyc_busy", 32'(flash_busy_o), 32'd1);
    frame();
    chk("same_cyc_done", 32'(flash_done_o), 32'd1);
    tick();

    flash_rows_i = '0;
    flash_start_i = 1'b1;
    tick();
    flash_start_i = 1'b0;
    chk("z_busy", 32'(flash_busy_o), 32'd1);
    chk("z_done_early", 32'(flash_done_o), 32'd0);
    tick();
    chk("z_done", 32'(flash_done_o), 32'd1);
    tick();
    chk("z_done_end", 32'(flash_done_o), 32'd0);
    chk("z_idle", 32'(flash_busy_o), 32'd0);

    flash_rows_i = 20'h00002;
    flash_start_i = 1'b1;
    tick();
    flash_start_i = 1'b0;
    frame();
    frame();
    chk("r_busy_off", 32'(flash_busy_o), 32'd1);
    rst_i = 1'b1;
    tick();
    snap = '0;
    chk("r_busy", 32'(flash_busy_o), 32'd0);
    chk("r_done", 32'(flash_done_o), 32'd0);
    chk("r_data", 32'(vga_data_o), 32'd0);
    chk("r_en", 32'(vga_data_en_o), 32'd0);
    rst_i = 1'b0;
    repeat (4) begin
      tick();
      chk("r_no_done", 32'(flash_done_o), 32'd0);
    end
    pix(0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
